// File: rtl/seq_link_pkg.sv
// Shared constants for the serial 101-preamble link (transmitter and detector).
package seq_link_pkg;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PREAMBLE = 3'd1;
    localparam logic [2:0] DATA     = 3'd2;
    localparam logic [2:0] PARITY   = 3'd3;
    localparam logic [2:0] GAP      = 3'd4;

    localparam logic [2:0]  SEQ_PREAMBLE     = 3'b101;
    localparam int unsigned SEQ_PREAMBLE_LEN = 3;

endpackage

// File: rtl/seq_piso.sv
// Parallel-in / serial-out shift register; load has priority, MSB is presented first.
module seq_piso #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_msb
);

    logic [W-1:0] r_shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
        end else if (i_shift) begin
            r_shreg <= r_shreg << 1;
        end
    end

    assign o_msb = r_shreg[W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Frame transmitter: preamble 101, DATA_W payload bits MSB-first, optional even parity, idle gap.
module seq_frame_tx
    import seq_link_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              data_out,
    output logic              busy,
    output logic              tx_done
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [1:0]  PRE_LAST   = 2'(SEQ_PREAMBLE_LEN - 1);
    localparam logic [2:0]  POST_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;
    localparam logic [2:0]  POST_DATA  = (PARITY_EN != 0) ? PARITY : POST_FRAME;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nx;
    logic [1:0]       r_pidx;
    logic [CNT_W-1:0] r_cnt;
    logic [GAP_W-1:0] r_gcnt;
    logic             r_parity;
    logic             r_data_out;
    logic             r_busy;
    logic             r_tx_done;

    logic             w_accept;
    logic             w_last_pre;
    logic             w_last_data;
    logic             w_last_gap;
    logic [1:0]       w_pidx_inc;
    logic             w_msb;
    logic             w_bit_nx;
    logic             w_done_nx;
    logic             w_load;
    logic             w_shift;

    assign in_ready    = (r_state == IDLE) & ~reset;
    assign w_accept    = in_ready & in_valid;
    assign w_last_pre  = (r_pidx == PRE_LAST);
    assign w_last_data = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_last_gap  = (r_gcnt == GAP_W'(GAP_CYCLES - 1));
    assign w_pidx_inc  = r_pidx + 2'd1;

    seq_piso #(.W(DATA_W)) u_piso (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (in_data),
        .o_msb   (w_msb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:     if (w_accept)    w_state_nx = PREAMBLE;
            PREAMBLE: if (w_last_pre)  w_state_nx = DATA;
            DATA:     if (w_last_data) w_state_nx = POST_DATA;
            PARITY:                    w_state_nx = POST_FRAME;
            GAP:      if (w_last_gap)  w_state_nx = IDLE;
            default:                   w_state_nx = IDLE;
        endcase
    end

    // Next value of the registered line: the register always holds the bit of the current state.
    always_comb begin
        w_bit_nx  = 1'b0;
        w_done_nx = 1'b0;
        w_load    = 1'b0;
        w_shift   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_bit_nx = SEQ_PREAMBLE[PRE_LAST];
                    w_load   = 1'b1;
                end
            end
            PREAMBLE: begin
                if (w_last_pre) begin
                    w_bit_nx = w_msb;
                    w_shift  = 1'b1;
                end else begin
                    w_bit_nx = SEQ_PREAMBLE[PRE_LAST - w_pidx_inc];
                end
            end
            DATA: begin
                if (!w_last_data) begin
                    w_bit_nx = w_msb;
                    w_shift  = 1'b1;
                end else if (PARITY_EN != 0) begin
                    w_bit_nx = r_parity;
                end else begin
                    w_done_nx = 1'b1;
                end
            end
            PARITY:  w_done_nx = 1'b1;
            default: ;
        endcase
    end

    // Counters restart whenever their state is (re-)entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pidx     <= '0;
            r_cnt      <= '0;
            r_gcnt     <= '0;
            r_parity   <= 1'b0;
            r_data_out <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_pidx     <= (r_state == PREAMBLE && w_state_nx == PREAMBLE) ? w_pidx_inc : 2'd0;
            r_cnt      <= (r_state == DATA && w_state_nx == DATA) ? r_cnt + CNT_W'(1) : '0;
            r_gcnt     <= (r_state == GAP && w_state_nx == GAP) ? r_gcnt + GAP_W'(1) : '0;
            r_data_out <= w_bit_nx;
            r_busy     <= (w_state_nx != IDLE);
            r_tx_done  <= w_done_nx;
            if (w_accept) begin
                r_parity <= ^in_data;
            end
        end
    end

    assign data_out = r_data_out;
    assign busy     = r_busy;
    assign tx_done  = r_tx_done;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: default config (8,1,2) plus an (8,0,0) instance.
module tb_seq_frame_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data_a, in_data_b;
    logic       in_valid_a, in_valid_b;
    logic       in_ready_a, in_ready_b;
    logic       data_out_a, data_out_b;
    logic       busy_a, busy_b;
    logic       tx_done_a, tx_done_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_frame_tx #(.DATA_W(8), .PARITY_EN(1), .GAP_CYCLES(2)) u_dut_a (
        .clk(clk), .reset(reset), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .data_out(data_out_a), .busy(busy_a), .tx_done(tx_done_a)
    );

    seq_frame_tx #(.DATA_W(8), .PARITY_EN(0), .GAP_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .data_out(data_out_b), .busy(busy_b), .tx_done(tx_done_b)
    );

    // Reference 101 detector on the line of instance a.
    logic [2:0] det_hist;
    logic       seq_detected;
    always @(posedge clk) begin
        if (reset) det_hist <= 3'b000;
        else       det_hist <= {det_hist[1:0], data_out_a};
    end
    assign seq_detected = (det_hist == 3'b101);

    typedef struct {
        logic [7:0]  data;
        logic [13:0] bits;
        int          poke;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Send one frame on instance a and check every bit time plus the idle cycle after it.
    task automatic run_frame_a(input logic [7:0] d, input logic [13:0] bits, input int poke);
        @(negedge clk);
        in_data_a  = d;
        in_valid_a = 1'b1;
        check("ready_at_accept", 32'(in_ready_a), 32'd1);
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        in_data_a  = ~d;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == poke) begin
                in_valid_a = 1'b1;
                in_data_a  = 8'hFF;
            end else begin
                in_valid_a = 1'b0;
            end
            check($sformatf("bit%0d", i), 32'(data_out_a), 32'(bits[13-i]));
            check($sformatf("done%0d", i), 32'(tx_done_a), 32'(i == 12));
            check($sformatf("busy%0d", i), 32'(busy_a), 32'd1);
            check($sformatf("ready%0d", i), 32'(in_ready_a), 32'd0);
        end
        @(negedge clk);
        in_valid_a = 1'b0;
        check("idle_line", 32'(data_out_a), 32'd0);
        check("idle_busy", 32'(busy_a), 32'd0);
        check("idle_done", 32'(tx_done_a), 32'd0);
        check("idle_ready", 32'(in_ready_a), 32'd1);
    endtask

    initial begin
        logic [28:0] got2;
        logic [28:0] exp2;
        logic [11:0] exp5;
        int          low_cnt;
        int          det_cnt;
        int          det_idx;
        logic        resumed;

        vecs[0] = '{8'hA5, 14'b101_10100101_0_00, -1};
        vecs[1] = '{8'h07, 14'b101_00000111_1_00, -1};
        vecs[2] = '{8'h3C, 14'b101_00111100_0_00, 6};
        vecs[3] = '{8'hFF, 14'b101_11111111_0_00, 9};

        reset = 1'b1;
        in_data_a = 8'h00; in_valid_a = 1'b0;
        in_data_b = 8'h00; in_valid_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_line_a", 32'(data_out_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(tx_done_a), 32'd0);
        check("rst_ready_a", 32'(in_ready_a), 32'd0);
        check("rst_ready_b", 32'(in_ready_b), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready_a", 32'(in_ready_a), 32'd1);
        check("post_rst_ready_b", 32'(in_ready_b), 32'd1);

        for (int v = 0; v < 4; v++) begin
            run_frame_a(vecs[v].data, vecs[v].bits, vecs[v].poke);
        end

        // Back-to-back 0x07 then 0x80 with in_valid held.
        exp2 = {14'b101_00000111_1_00, 1'b0, 14'b101_10000000_1_00};
        low_cnt = 0;
        @(negedge clk);
        in_data_a  = 8'h07;
        in_valid_a = 1'b1;
        @(posedge clk);
        #1;
        in_data_a = 8'h80;
        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            got2[28-i] = data_out_a;
            if (!in_ready_a) low_cnt++;
            if (i == 14) check("b2b_ready_gap", 32'(in_ready_a), 32'd1);
            if (i == 15) in_valid_a = 1'b0;
        end
        check("b2b_bits", 32'(got2), 32'(exp2));
        check("b2b_ready_low", 32'(low_cnt), 32'd28);
        @(negedge clk);
        check("b2b_idle", 32'(busy_a), 32'd0);

        // Reset asserted while the third data bit is on the line.
        @(negedge clk);
        in_data_a  = 8'hA5;
        in_valid_a = 1'b1;
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        check("abort_bit", 32'(data_out_a), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_ready_in_rst", 32'(in_ready_a), 32'd0);
        @(negedge clk);
        check("abort_line", 32'(data_out_a), 32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_done", 32'(tx_done_a), 32'd0);
        reset = 1'b0;
        #1;
        check("abort_ready_after", 32'(in_ready_a), 32'd1);
        resumed = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            resumed = resumed | data_out_a | busy_a;
        end
        check("abort_no_resume", 32'(resumed), 32'd0);

        // No parity, no gap: 0x3C.
        exp5 = 12'b101_00111100_0;
        @(negedge clk);
        in_data_b  = 8'h3C;
        in_valid_b = 1'b1;
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("np_bit%0d", i), 32'(data_out_b), 32'(exp5[11-i]));
            check($sformatf("np_done%0d", i), 32'(tx_done_b), 32'(i == 11));
            check($sformatf("np_busy%0d", i), 32'(busy_b), 32'(i < 11));
            check($sformatf("np_ready%0d", i), 32'(in_ready_b), 32'(i == 11));
        end

        // Line into the reference detector with a zero payload.
        det_cnt = 0;
        det_idx = -1;
        @(negedge clk);
        in_data_a  = 8'h00;
        in_valid_a = 1'b1;
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (seq_detected) begin
                det_cnt++;
                det_idx = i;
            end
        end
        check("det_count", 32'(det_cnt), 32'd1);
        check("det_cycle", 32'(det_idx), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
